// File: rtl/state_poly_tomsg_pkg.sv
// Shared constants, FSM encoding and compression window for state_poly_tomsg.
// Share folding is compiled in when STATE_POLY_TOMSG_SHARE_FOLD_EN is defined.
package state_poly_tomsg_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    localparam int LANES  = 8;
    localparam int LANE_W = 16;
    localparam int COEF_W = 12;
    localparam int WORD_W = LANES * LANE_W;
    localparam int ADDR_W = 5;

    localparam logic [COEF_W:0]   Q_S    = 13'd3329;
    localparam logic [COEF_W:0]   THR_LO = 13'd833;
    localparam logic [COEF_W:0]   THR_HI = 13'd2496;
    localparam logic [ADDR_W-1:0] LAST_AD = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // round(2s/q) mod 2 is 1 exactly when s lies in [833, 2496]
    function automatic logic in_window(input logic [COEF_W:0] s);
        return (s >= THR_LO) && (s <= THR_HI);
    endfunction

endpackage

// File: rtl/state_poly_tomsg_compress.sv
// One coefficient lane: optional share fold mod q, then 1-bit poly_tomsg compression.
// Fold is present only when STATE_POLY_TOMSG_SHARE_FOLD_EN is defined.
module State_Poly_ToMsg___Compress
    import state_poly_tomsg_pkg::*;
(
    input  logic [COEF_W-1:0] x1,
    input  logic [COEF_W-1:0] x2,
    output logic              msg_bit
);

    logic [COEF_W:0] s;

`ifdef STATE_POLY_TOMSG_SHARE_FOLD_EN
    logic [COEF_W:0] sum;

    // Both shares are canonical, so one conditional subtract fully reduces
    always_comb begin
        sum = {1'b0, x1} + {1'b0, x2};
        s   = sum;
        if (sum >= Q_S) begin
            s = sum - Q_S;
        end
    end
`else
    logic unused_x2;

    assign unused_x2 = ^x2;
    assign s         = {1'b0, x1};
`endif

    assign msg_bit = in_window(s);

endmodule

// File: rtl/state_poly_tomsg.sv
// Streams 32 subtract-stage words, compresses each 8-lane word to one message byte.
// STATE_POLY_TOMSG_SHARE_FOLD_EN adds share 2 into share 1 mod q before compression.
module state_poly_tomsg
    import state_poly_tomsg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] Sub_DecMp_RAd,
    input  logic [WORD_W-1:0] Sub_DecMp1_RData,
    input  logic [WORD_W-1:0] Sub_DecMp2_RData,
    output logic              Msg_outready,
    output logic [ADDR_W-1:0] Msg_WAd,
    output logic [LANES-1:0]  Msg_WData,
    output logic              Busy,
    output logic              Function_done,
    output state_t            dbg_state
);

    state_t            state;
    state_t            state_nx;
    logic              rd_v;
    logic [ADDR_W-1:0] rd_ad_d;
    logic [LANES-1:0]  msg_bits;
    logic [LANES-1:0]  unused_nib;
    logic              last_wr;

    // Lane i occupies bits [16i+15:16i]; only the low 12 bits carry the coefficient
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        State_Poly_ToMsg___Compress u_cmp (
            .x1      (Sub_DecMp1_RData[LANE_W*i +: COEF_W]),
            .x2      (Sub_DecMp2_RData[LANE_W*i +: COEF_W]),
            .msg_bit (msg_bits[i])
        );

        assign unused_nib[i] = ^{Sub_DecMp1_RData[LANE_W*i+COEF_W +: LANE_W-COEF_W],
                                 Sub_DecMp2_RData[LANE_W*i+COEF_W +: LANE_W-COEF_W]};
    end

    assign last_wr   = Msg_outready && (Msg_WAd == LAST_AD);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (enable)                      state_nx = ST_RUN;
            ST_RUN:   if (Sub_DecMp_RAd == LAST_AD)    state_nx = ST_DRAIN;
            ST_DRAIN: if (last_wr)                     state_nx = ST_IDLE;
            default:                                   state_nx = ST_IDLE;
        endcase
    end

    // rd_v marks the cycle a word is on RData; Msg_WAd trails RAd by two cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            Sub_DecMp_RAd <= '0;
            rd_v          <= 1'b0;
            rd_ad_d       <= '0;
            Msg_outready  <= 1'b0;
            Msg_WAd       <= '0;
            Msg_WData     <= '0;
            Busy          <= 1'b0;
            Function_done <= 1'b0;
        end else begin
            state         <= state_nx;
            rd_v          <= (state == ST_RUN);
            rd_ad_d       <= Sub_DecMp_RAd;
            Msg_outready  <= rd_v;
            Function_done <= (state == ST_DRAIN) && last_wr;

            if (rd_v) begin
                Msg_WAd   <= rd_ad_d;
                Msg_WData <= msg_bits;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        Sub_DecMp_RAd <= '0;
                        Busy          <= 1'b1;
                    end
                end
                ST_RUN: begin
                    Sub_DecMp_RAd <= Sub_DecMp_RAd + 1'b1;
                end
                ST_DRAIN: begin
                    if (last_wr) begin
                        Busy <= 1'b0;
                    end
                end
                default: begin
                    Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_poly_tomsg.sv
// Directed bench for state_poly_tomsg: threshold/fold table words, full stream timing,
// back-to-back starts, ignored enables and reset mid-run.
module tb_state_poly_tomsg;
    import state_poly_tomsg_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [4:0]   rad;
    logic [127:0] rd1;
    logic [127:0] rd2;
    logic         outready;
    logic [4:0]   wad;
    logic [7:0]   wdata;
    logic         busy;
    logic         done;
    state_t       dbg_state;

    int total = 0;
    int bad = 0;

    logic [127:0] mem1 [32];
    logic [127:0] mem2 [32];
    logic [7:0]   exp_bytes [32];
    logic [7:0]   exp_q [$];

    typedef struct {
        logic [127:0] w1;
        logic [127:0] w2;
        logic [7:0]   exp_fold;
        logic [7:0]   exp_plain;
    } vec_t;

    vec_t vecs [6];

    state_poly_tomsg dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .Sub_DecMp_RAd    (rad),
        .Sub_DecMp1_RData (rd1),
        .Sub_DecMp2_RData (rd2),
        .Msg_outready     (outready),
        .Msg_WAd          (wad),
        .Msg_WData        (wdata),
        .Busy             (busy),
        .Function_done    (done),
        .dbg_state        (dbg_state)
    );

    // clock / BRAM model with one cycle of read latency
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= mem1[rad];
        rd2 <= mem2[rad];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // golden poly_tomsg using the division form
    function automatic logic [7:0] model_byte(input logic [127:0] w1, input logic [127:0] w2);
        logic [7:0] b;
        int x1, x2, s;
        for (int i = 0; i < 8; i++) begin
            x1 = int'(w1[16*i +: 12]);
            x2 = int'(w2[16*i +: 12]);
`ifdef STATE_POLY_TOMSG_SHARE_FOLD_EN
            s = (x1 + x2) % KYBER_Q;
`else
            s = x1 + 0 * x2;
`endif
            b[i] = (((2 * s + 1664) / KYBER_Q) % 2) == 1;
        end
        return b;
    endfunction

    task automatic fill_random();
        for (int a = 0; a < 32; a++) begin
            for (int l = 0; l < 8; l++) begin
                mem1[a][16*l +: 16] = {4'($urandom_range(0, 15)), 12'($urandom_range(0, 3328))};
                mem2[a][16*l +: 16] = {4'($urandom_range(0, 15)), 12'($urandom_range(0, 3328))};
            end
            exp_bytes[a] = model_byte(mem1[a], mem2[a]);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 6; i++) begin
            mem1[i*6] = vecs[i].w1;
            mem2[i*6] = vecs[i].w2;
`ifdef STATE_POLY_TOMSG_SHARE_FOLD_EN
            exp_bytes[i*6] = vecs[i].exp_fold;
`else
            exp_bytes[i*6] = vecs[i].exp_plain;
`endif
        end
    endtask

    // Called at the negedge of cycle 0; returns at the negedge of cycle 35
    task automatic do_run(input bit hold, input bit poke);
        exp_q.delete();
        for (int a = 0; a < 32; a++) exp_q.push_back(exp_bytes[a]);
        enable = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!hold) enable = 1'b0;
                chk("done_low_c1", done, 0);
                chk("busy_c1", busy, 1);
            end
            if (poke) enable = (c == 5) || (c == 20);
            if (c <= 32) chk("rd_addr", rad, c - 1);
            if (c == 2) chk("no_wr_c2", outready, 0);
            if (c >= 3 && c <= 34) begin
                chk("wr_strobe", outready, 1);
                chk("wr_addr", wad, c - 3);
                if (exp_q.size() > 0) chk("wr_data", wdata, exp_q.pop_front());
            end
            if (c == 33) chk("state_drain", dbg_state, ST_DRAIN);
            if (c == 34) chk("busy_c34", busy, 1);
            if (c == 35) begin
                chk("done_c35", done, 1);
                chk("busy_c35", busy, 0);
                chk("no_wr_c35", outready, 0);
                chk("wdata_hold", wdata, exp_bytes[31]);
                chk("bytes_left", exp_q.size(), 0);
            end
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("state_idle", dbg_state, ST_IDLE);
        chk("no_wr_idle", outready, 0);
    endtask

    initial begin
        vecs[0] = '{mk(0, 832, 833, 1664, 2496, 2497, 3328, 1), '0, 8'h1C, 8'h1C};
        vecs[1] = '{mk(3000, 2000, 1000, 0, 1664, 3328, 2496, 2000),
                    mk(1000, 2000, 500, 0, 0, 1, 0, 496), 8'hD4, 8'hD6};
        vecs[2] = '{mk('hF680, 'hF680, 'hF680, 'hF680, 'hF680, 'hF680, 'hF680, 'hF680),
                    mk('hA000, 'hA000, 'hA000, 'hA000, 'hA000, 'hA000, 'hA000, 'hA000), 8'hFF, 8'hFF};
        vecs[3] = '{'0, '0, 8'h00, 8'h00};
        vecs[4] = '{mk(832, 2497, 0, 3328, 833, 2496, 1, 1665), '0, 8'hB0, 8'hB0};
        vecs[5] = '{mk(3328, 3328, 1664, 0, 2000, 100, 416, 416),
                    mk(3328, 1, 1664, 833, 3328, 733, 417, 416), 8'h78, 8'h14};
        fill_random();

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rad", rad, 0);
        chk("rst_outready", outready, 0);
        chk("rst_wad", wad, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        // table words plus random fill, with enable pokes mid-run
        load_table();
        do_run(1'b0, 1'b1);
        check_idle_after();

        // back-to-back: enable held through the done cycle
        fill_random();
        do_run(1'b1, 1'b0);
        do_run(1'b0, 1'b0);
        check_idle_after();

        // reset asserted in cycle 15
        fill_random();
        enable = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) enable = 1'b0;
            if (c == 15) rst_n = 1'b0;
        end
        chk("abort_rad", rad, 0);
        chk("abort_outready", outready, 0);
        chk("abort_wad", wad, 0);
        chk("abort_wdata", wdata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        load_table();
        do_run(1'b0, 1'b0);
        check_idle_after();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
